// File: rtl/ee457_pipe_pkg.sv
// ee457_pipe_pkg
//   Shared types and helpers for the ee457_param_pipe constant-arithmetic
//   pipeline.
//   - pipe_slot_t : one EX/WB stage slot (valid, mask, ra, data, d, f).
//                   Field widths are sized for the largest supported
//                   configuration. Unused upper bits are held at zero.
//   - MASK_MOV    : mask value that selects no stage adds (plain move).
//   - need_stage  : lowest set mask bit, or nex for a move.
//   - last_stage  : highest set mask bit, or -1 for a move.
package ee457_pipe_pkg;

  localparam int PIPE_DW_MAX  = 32;
  localparam int PIPE_RW_MAX  = 8;
  localparam int PIPE_NEX_MAX = 8;
  // Wide enough to hold distances and stage indices 0..PIPE_NEX_MAX.
  localparam int PIPE_DIST_W  = 4;

  localparam logic [PIPE_NEX_MAX-1:0] MASK_MOV = '0;

  typedef struct packed {
    logic                    valid;
    logic [PIPE_NEX_MAX-1:0] mask;
    logic [PIPE_RW_MAX-1:0]  ra;
    logic [PIPE_DW_MAX-1:0]  data;
    logic [PIPE_DIST_W-1:0]  d;
    logic [PIPE_DIST_W-1:0]  f;
  } pipe_slot_t;

  function automatic int need_stage(input logic [PIPE_NEX_MAX-1:0] mask,
                                    input int nex);
    need_stage = nex;
    for (int k = PIPE_NEX_MAX - 1; k >= 0; k--) begin
      if (k < nex && mask[k]) need_stage = k;
    end
  endfunction

  function automatic int last_stage(input logic [PIPE_NEX_MAX-1:0] mask,
                                    input int nex);
    last_stage = -1;
    for (int k = 0; k < PIPE_NEX_MAX; k++) begin
      if (k < nex && mask[k]) last_stage = k;
    end
  endfunction

endpackage

// File: rtl/ee457_regfile_byp.sv
// ee457_regfile_byp
//   2^RW x DW register file with synchronous active-low clear.
//   Ports:
//     i_clk, i_rst_b            : clock, synchronous active-low reset
//     i_wr_en/addr/data         : write port (from the WB stage)
//     i_rd_addr -> o_rd_data    : ID read, bypassed from a same-cycle write
//     i_dbg_addr -> o_dbg_data  : debug read of stored contents, no bypass
module ee457_regfile_byp #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_b,
  input  logic          i_wr_en,
  input  logic [RW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [RW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  input  logic [RW-1:0] i_dbg_addr,
  output logic [DW-1:0] o_dbg_data
);

  logic [DW-1:0] r_mem [1<<RW];

  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      for (int i = 0; i < (1 << RW); i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data  = (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_data : r_mem[i_rd_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/ee457_param_pipe.sv
// ee457_param_pipe
//   In-order pipeline: ID, NEX execute stages, WB. Each instruction reads
//   in_xa, optionally adds STAGE_K slice k at EX stage k (in_mask bit k),
//   and writes in_ra. Full forwarding with youngest-producer priority and
//   an ID-only stall.
//   Ports:
//     CLK, RSTB                    : clock, synchronous active-low reset
//     in_valid/in_ready            : instruction stream handshake
//     in_mask, in_xa, in_ra        : instruction fields
//     stall                        : ID holding a valid instruction
//     wb_valid, wb_ra, wb_data     : retiring write
//     dbg_a -> dbg_d               : debug register read
module ee457_param_pipe
  import ee457_pipe_pkg::*;
#(
  parameter int              DW      = 16,
  parameter int              RW      = 4,
  parameter int              NEX     = 2,
  parameter logic [NEX*DW-1:0] STAGE_K = {16'd4, 16'hFFFD}
) (
  input  logic           CLK,
  input  logic           RSTB,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [NEX-1:0] in_mask,
  input  logic [RW-1:0]  in_xa,
  input  logic [RW-1:0]  in_ra,
  output logic           stall,
  output logic           wb_valid,
  output logic [RW-1:0]  wb_ra,
  output logic [DW-1:0]  wb_data,
  input  logic [RW-1:0]  dbg_a,
  output logic [DW-1:0]  dbg_d
);

  localparam logic [PIPE_DW_MAX-1:0] DMASK = {PIPE_DW_MAX{1'b1}} >> (PIPE_DW_MAX - DW);

  logic                    r_id_valid;
  logic [PIPE_NEX_MAX-1:0] r_id_mask;
  logic [RW-1:0]           r_id_xa;
  logic [RW-1:0]           r_id_ra;
  pipe_slot_t              r_ex [NEX];
  pipe_slot_t              r_wb;

  logic [PIPE_NEX_MAX-1:0] w_in_mask_ext;
  logic [PIPE_RW_MAX-1:0]  w_xa_ext;
  logic [DW-1:0]           w_rd_data;
  logic                    w_hit;
  int                      w_d;
  int                      w_f;
  int                      w_c;
  int                      w_l;
  logic                    w_stall;
  pipe_slot_t              w_id_slot;
  pipe_slot_t              w_next [NEX];
  logic [PIPE_DW_MAX-1:0]  w_eff [NEX+1];
  logic [PIPE_DW_MAX-1:0]  w_kadd;
  logic                    w_unused_wb;

  always_comb begin
    w_in_mask_ext = MASK_MOV;
    w_in_mask_ext[NEX-1:0] = in_mask;
  end

  // Hazard check: scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_xa_ext = '0;
    w_xa_ext[RW-1:0] = r_id_xa;
    w_hit = 1'b0;
    w_d   = 0;
    w_l   = -1;
    for (int j = NEX - 1; j >= 0; j--) begin
      if (r_ex[j].valid && (r_ex[j].ra == w_xa_ext)) begin
        w_hit = 1'b1;
        w_d   = j + 1;
        w_l   = last_stage(r_ex[j].mask, NEX);
      end
    end
    w_c = need_stage(r_id_mask, NEX);
    w_f = (w_c < (NEX - w_d)) ? w_c : (NEX - w_d);
    w_stall = r_id_valid && w_hit && (w_l >= (w_f + w_d));
  end

  always_comb begin
    w_id_slot = '0;
    if (!w_stall) begin
      w_id_slot.valid = r_id_valid;
      w_id_slot.mask  = r_id_mask;
      w_id_slot.ra[RW-1:0]   = r_id_ra;
      w_id_slot.data[DW-1:0] = w_rd_data;
      if (w_hit) begin
        w_id_slot.d = PIPE_DIST_W'(w_d);
        w_id_slot.f = PIPE_DIST_W'(w_f);
      end
    end
  end

  // Stage datapath, evaluated from WB back to EX0. w_eff[s] is stage s's
  // operand after its own forward but before its add; a consumer picks up
  // w_eff of its producer so a move that is itself forwarding in the same
  // cycle still hands on the resolved value.
  always_comb begin
    w_eff[NEX] = r_wb.data;
    w_kadd = '0;
    for (int k = NEX - 1; k >= 0; k--) begin
      w_eff[k] = r_ex[k].data;
      if (r_ex[k].valid && (r_ex[k].d != '0) && (int'(r_ex[k].f) == k)) begin
        for (int s = 1; s <= NEX; s++) begin
          if ((s > k) && ((s - k) == int'(r_ex[k].d))) w_eff[k] = w_eff[s];
        end
      end
      w_kadd = '0;
      w_kadd[DW-1:0] = STAGE_K[k*DW +: DW];
      w_next[k] = r_ex[k];
      w_next[k].data = r_ex[k].mask[k] ? ((w_eff[k] + w_kadd) & DMASK) : w_eff[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      r_id_valid <= 1'b0;
      r_id_mask  <= MASK_MOV;
      r_id_xa    <= '0;
      r_id_ra    <= '0;
      for (int k = 0; k < NEX; k++) r_ex[k] <= '0;
      r_wb <= '0;
    end else begin
      if (!w_stall) begin
        r_id_valid <= in_valid;
        r_id_mask  <= w_in_mask_ext;
        r_id_xa    <= in_xa;
        r_id_ra    <= in_ra;
      end
      r_ex[0] <= w_id_slot;
      for (int k = 1; k < NEX; k++) r_ex[k] <= w_next[k-1];
      r_wb <= w_next[NEX-1];
    end
  end

  ee457_regfile_byp #(
    .DW(DW),
    .RW(RW)
  ) u_regfile (
    .i_clk      (CLK),
    .i_rst_b    (RSTB),
    .i_wr_en    (r_wb.valid),
    .i_wr_addr  (r_wb.ra[RW-1:0]),
    .i_wr_data  (r_wb.data[DW-1:0]),
    .i_rd_addr  (r_id_xa),
    .o_rd_data  (w_rd_data),
    .i_dbg_addr (dbg_a),
    .o_dbg_data (dbg_d)
  );

  assign in_ready = ~w_stall;
  assign stall    = w_stall;
  assign wb_valid = r_wb.valid;
  assign wb_ra    = r_wb.ra[RW-1:0];
  assign wb_data  = r_wb.data[DW-1:0];

  // WB slot bookkeeping fields have no consumer past this point.
  assign w_unused_wb = ^{r_wb.ra, r_wb.mask, r_wb.d, r_wb.f};

endmodule

// File: tb/tb_ee457_param_pipe.sv
module tb_ee457_param_pipe;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  // Default-configuration DUT (NEX=2, bit0 = -3, bit1 = +4)
  logic        a_valid, a_ready, a_stall, a_wbv;
  logic [1:0]  a_mask;
  logic [3:0]  a_xa, a_ra, a_wbra, a_dbga;
  logic [15:0] a_wbd, a_dbgd;

  // NEX=4 DUT, slice k addend = 4,3,2,1 for k = 0..3
  logic        b_valid, b_ready, b_stall, b_wbv;
  logic [3:0]  b_mask;
  logic [3:0]  b_xa, b_ra, b_wbra, b_dbga;
  logic [15:0] b_wbd, b_dbgd;

  ee457_param_pipe u_a (
    .CLK(clk), .RSTB(rstb),
    .in_valid(a_valid), .in_ready(a_ready), .in_mask(a_mask), .in_xa(a_xa), .in_ra(a_ra),
    .stall(a_stall), .wb_valid(a_wbv), .wb_ra(a_wbra), .wb_data(a_wbd),
    .dbg_a(a_dbga), .dbg_d(a_dbgd)
  );

  ee457_param_pipe #(
    .NEX(4),
    .STAGE_K({16'd1, 16'd2, 16'd3, 16'd4})
  ) u_b (
    .CLK(clk), .RSTB(rstb),
    .in_valid(b_valid), .in_ready(b_ready), .in_mask(b_mask), .in_xa(b_xa), .in_ra(b_ra),
    .stall(b_stall), .wb_valid(b_wbv), .wb_ra(b_wbra), .wb_data(b_wbd),
    .dbg_a(b_dbga), .dbg_d(b_dbgd)
  );

  int total = 0;
  int bad = 0;
  int a_stall_seen = 0;
  int b_stall_seen = 0;
  int a_wb_seen = 0;
  logic [19:0] qa[$];
  logic [19:0] qb[$];
  logic [19:0] mon_exp;

  // Monitor: pop expected writebacks as the DUTs retire them.
  always @(negedge clk) begin
    if (a_stall === 1'b1) a_stall_seen++;
    if (b_stall === 1'b1) b_stall_seen++;
    if (a_wbv === 1'b1) begin
      a_wb_seen++;
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL sb_a_unexpected: got wb ra=%0d data=%h, required no writeback", a_wbra, a_wbd);
      end else begin
        mon_exp = qa.pop_front();
        if ({a_wbra, a_wbd} !== mon_exp) begin
          bad++;
          $display("FAIL sb_a_wb: got ra=%0d data=%h, required ra=%0d data=%h",
                   a_wbra, a_wbd, mon_exp[19:16], mon_exp[15:0]);
        end
      end
    end
    if (b_wbv === 1'b1) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL sb_b_unexpected: got wb ra=%0d data=%h, required no writeback", b_wbra, b_wbd);
      end else begin
        mon_exp = qb.pop_front();
        if ({b_wbra, b_wbd} !== mon_exp) begin
          bad++;
          $display("FAIL sb_b_wb: got ra=%0d data=%h, required ra=%0d data=%h",
                   b_wbra, b_wbd, mon_exp[19:16], mon_exp[15:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask

  // Offer one instruction; called just after a negedge.
  task automatic issue_a(input logic [1:0] m, input logic [3:0] xa, input logic [3:0] ra,
                         input logic [15:0] exp, input bit push);
    logic acc;
    int n;
    a_valid = 1'b1; a_mask = m; a_xa = xa; a_ra = ra;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      acc = a_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    a_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL issue_a_timeout: got in_ready low for %0d cycles, required acceptance", n);
    end else if (push) begin
      qa.push_back({ra, exp});
    end
  endtask

  task automatic issue_b(input logic [3:0] m, input logic [3:0] xa, input logic [3:0] ra,
                         input logic [15:0] exp);
    logic acc;
    int n;
    b_valid = 1'b1; b_mask = m; b_xa = xa; b_ra = ra;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      acc = b_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    b_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL issue_b_timeout: got in_ready low for %0d cycles, required acceptance", n);
    end else begin
      qb.push_back({ra, exp});
    end
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_a(input string nm, input logic [3:0] a, input logic [15:0] want);
    a_dbga = a;
    #1;
    chk(nm, {16'h0, a_dbgd}, {16'h0, want});
  endtask

  task automatic rd_b(input string nm, input logic [3:0] a, input logic [15:0] want);
    b_dbga = a;
    #1;
    chk(nm, {16'h0, b_dbgd}, {16'h0, want});
  endtask

  int s0;
  int w0;

  initial begin
    a_valid = 1'b0; a_mask = '0; a_xa = '0; a_ra = '0; a_dbga = '0;
    b_valid = 1'b0; b_mask = '0; b_xa = '0; b_ra = '0; b_dbga = '0;
    rstb = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_in_ready", {31'h0, a_ready}, 32'd1);
    chk("rst_stall", {31'h0, a_stall}, 32'd0);
    chk("rst_wb_valid", {31'h0, a_wbv}, 32'd0);
    chk("rst_wb_ra", {28'h0, a_wbra}, 32'd0);
    chk("rst_wb_data", {16'h0, a_wbd}, 32'd0);
    chk("rst_b_in_ready", {31'h0, b_ready}, 32'd1);
    for (int i = 0; i < 16; i++) rd_a($sformatf("rst_r%0d", i), i[3:0], 16'h0000);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // Dependent stall, plus a third instruction held off while ID stalls
    s0 = a_stall_seen;
    issue_a(2'b11, 4'd0, 4'd1, 16'h0001, 1'b1);
    issue_a(2'b01, 4'd1, 4'd3, 16'hFFFE, 1'b1);
    issue_a(2'b10, 4'd0, 4'd6, 16'h0004, 1'b1);
    idle(8);
    chk("t1_stall_cycles", 32'(a_stall_seen - s0), 32'd1);
    rd_a("t1_r1", 4'd1, 16'h0001);
    rd_a("t1_r3", 4'd3, 16'hFFFE);
    rd_a("t1_r6", 4'd6, 16'h0004);
    @(negedge clk);

    // WB forward, no stall
    s0 = a_stall_seen;
    issue_a(2'b01, 4'd0, 4'd2, 16'hFFFD, 1'b1);
    issue_a(2'b10, 4'd2, 4'd3, 16'h0001, 1'b1);
    idle(8);
    chk("t2_stall_cycles", 32'(a_stall_seen - s0), 32'd0);
    rd_a("t2_r2", 4'd2, 16'hFFFD);
    rd_a("t2_r3", 4'd3, 16'h0001);
    @(negedge clk);

    // Youngest-producer priority
    issue_a(2'b10, 4'd0, 4'd1, 16'h0004, 1'b1);
    idle(8);
    s0 = a_stall_seen;
    issue_a(2'b01, 4'd1, 4'd4, 16'h0001, 1'b1);
    issue_a(2'b00, 4'd1, 4'd4, 16'h0004, 1'b1);
    issue_a(2'b10, 4'd4, 4'd5, 16'h0008, 1'b1);
    idle(8);
    chk("t3_stall_cycles", 32'(a_stall_seen - s0), 32'd0);
    rd_a("t3_r1", 4'd1, 16'h0004);
    rd_a("t3_r4", 4'd4, 16'h0004);
    rd_a("t3_r5", 4'd5, 16'h0008);
    @(negedge clk);

    // Mid-flight reset: pulse during the second instruction's EX0 cycle
    w0 = a_wb_seen;
    issue_a(2'b11, 4'd0, 4'd7, 16'h0001, 1'b0);
    issue_a(2'b11, 4'd0, 4'd8, 16'h0001, 1'b0);
    issue_a(2'b11, 4'd0, 4'd9, 16'h0001, 1'b0);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    idle(8);
    chk("t4_wb_count", 32'(a_wb_seen - w0), 32'd0);
    for (int i = 0; i < 16; i++) rd_a($sformatf("t4_r%0d", i), i[3:0], 16'h0000);
    @(negedge clk);

    // NEX=4 chain: three stall cycles
    s0 = b_stall_seen;
    issue_b(4'b1111, 4'd0, 4'd1, 16'd10);
    issue_b(4'b0001, 4'd1, 4'd2, 16'd14);
    idle(12);
    chk("t5_stall_cycles", 32'(b_stall_seen - s0), 32'd3);
    rd_b("t5_r1", 4'd1, 16'd10);
    rd_b("t5_r2", 4'd2, 16'd14);
    @(negedge clk);

    chk("sb_a_drained", 32'(qa.size()), 32'd0);
    chk("sb_b_drained", 32'(qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ee457_param_pipe.md
# ee457_param_pipe

Parametrised in-order constant-arithmetic pipeline: ID stage, `NEX` execute stages, WB stage. Each instruction reads one source register, optionally applies a per-stage constant add at each EX stage selected by its mask, and writes one destination register. It provides full forwarding with youngest-producer priority and a single-cycle-granular ID stall. It accepts instructions over a valid/ready stream and sits in the lab datapath in place of the fixed SUB3/ADD4 pipeline.

## Interface
- `DW`, 16: data and register width.
- `RW`, 4: register-address width; the register file has 2^RW entries.
- `NEX`, 2: number of EX stages, 1..8.
- `STAGE_K`, {16'd4,16'hFFFD}: NEX×DW packed constants.
  - Slice k is the stage-k addend.
  - The default reproduces the SUB3 then ADD4 arrangement.
- `CLK` in 1: clock; single clock domain.
- `RSTB` in 1: reset, synchronous, active-low.
- `in_valid` in 1: an instruction is offered.
- `in_ready` out 1: the block accepts the offered instruction.
- `in_mask` in NEX: bit k set means stage k adds `STAGE_K[k]`. All zeros is MOV.
- `in_xa` in RW: source register.
- `in_ra` in RW: destination register.
- `stall` out 1: ID is holding a valid instruction this cycle.
- `wb_valid` out 1: a retiring instruction writes this cycle.
- `wb_ra` out RW: retiring destination register.
- `wb_data` out DW: retiring write data.
- `dbg_a` in RW: debug read address.
- `dbg_d` out DW: debug read data, combinational, no bypass.

## Operation
- Stage slots:
  - ID holds an instruction.
  - EX0..EX(NEX-1) and WB each hold: valid, mask, ra, data, fwd distance `d` (0 means none), fwd stage `f`.
- `in_ready = ~stall`. An offered instruction is loaded into ID on `in_valid & in_ready`. When nothing is offered, ID loads a bubble.
- Per-instruction quantities:
  - Need stage `c` = lowest set mask bit; `c = NEX` for MOV.
  - Last-op stage `l` = highest set mask bit; `l = -1` for MOV.
- ID operand read:
  - The register file is read at `in_xa`.
  - If WB is valid and `wb_ra == xa`, the read is bypassed to `wb_data`.
- ID dependency check:
  - Find the youngest valid EX_j whose ra equals xa; set `d = j+1`.
  - Set `f = min(c, NEX-d)`.
  - `stall = 1` iff a match exists and producer `l ≥ f+d`.
  - The check is re-evaluated every cycle while stalled.
- On stall, a bubble (valid = 0) enters EX0 and ID holds its instruction.
- Every EX stage always advances; only ID stalls.
- At stage k, in a valid slot with `d ≠ 0` and `f == k`:
  - data is replaced by the data currently held in the input register of stage k+d.
  - Stage index NEX means the WB register.
  - Lockstep advance guarantees the producer is exactly d stages ahead.
- Then, if `mask[k]`, data becomes data + `STAGE_K[k]`, modulo 2^DW.
- WB: if valid, write `wb_data` to register `wb_ra` at the end of the cycle. The write has no condition other than valid.
- Writes to the same register are applied in program order.

## Timing
- Reset (RSTB low at an edge):
  - All slots invalid; all register-file entries are 0.
  - `in_ready = 1`, `stall = 0`, `wb_valid = 0`, `wb_ra = 0`, `wb_data = 0`.
  - Reset mid-operation discards all in-flight instructions with no writeback.
- Latency: an instruction accepted at edge e0 is:
  - in ID during cycle 1,
  - in EX_k during cycle k+2,
  - in WB during cycle NEX+2,
  - visible on `dbg_d` after the edge that ends the WB cycle.
- Each stall cycle adds one cycle to the latency.
- A stalled instruction never lasts more than NEX cycles in ID.
- A bubble is inserted for each stall cycle; there is no throughput loss otherwise.
- `stall` and `in_ready` are combinational from ID and EX state. They do not depend on `in_valid`.

## Structure
- Package `ee457_pipe_pkg` holds:
  - the stage-slot struct (valid, mask, ra, data, d, f),
  - the MOV mask constant,
  - the `need_stage` / `last_stage` functions.
- Sub-module `ee457_regfile_byp` contains:
  - 2^RW×DW storage with synchronous reset,
  - the ID read port with WB bypass,
  - the debug read port.
- The hazard, forward and stage logic is generated per stage in the top level.

## Test plan
Defaults throughout; mask bit0 = −3, bit1 = +4.
- Reset: RSTB low for 2 cycles → `in_ready = 1`, `wb_valid = 0`, all `dbg_d = 0`.
- Dependent stall: mask 11 R1←R0, then mask 01 R3←R1 back-to-back.
  - `stall` is high for exactly 1 cycle.
  - R1 = 0x0001, R3 = 0xFFFE.
- WB forward, no stall: mask 01 R2←R0, then mask 10 R3←R2.
  - No stall.
  - R2 = 0xFFFD, R3 = 0x0001.
- Youngest-producer priority: with R1 = 4 preloaded, issue mask 01 R4←R1; 00 R4←R1; 10 R5←R4 consecutively.
  - No stall.
  - R4 = 4, R5 = 8.
- Mid-flight reset: issue 3 valid instructions, then pulse RSTB low for 1 cycle during the second one's EX0.
  - `wb_valid` stays 0.
  - All registers read 0.
- `NEX = 4`, `STAGE_K = {1,2,3,4}`: mask 1111 R1←R0, then mask 0001 R2←R1.
  - `stall` is high for 3 cycles.
  - R1 = 10, R2 = 14.
